// File: rtl/div_pkg.sv
// Shared types and result helpers for the iterative RISC-V M-extension divider.
package div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  function automatic logic [31:0] div_abs(input logic [31:0] v, input logic neg);
    logic [31:0] r;
    if (neg) r = 32'd0 - v;
    else     r = v;
    return r;
  endfunction

  // Sign correction plus divide-by-zero results; overflow needs no special case.
  function automatic logic [31:0] div_fix(
    input div_op_t     op,
    input logic [31:0] a,
    input logic [31:0] q,
    input logic [31:0] r,
    input logic        a_neg,
    input logic        b_neg,
    input logic        b_zero
  );
    logic [31:0] res_v;
    res_v = 32'd0;
    case (op)
      OP_DIV: begin
        if (b_zero)              res_v = 32'hFFFF_FFFF;
        else if (a_neg ^ b_neg)  res_v = 32'd0 - q;
        else                     res_v = q;
      end
      OP_DIVU: begin
        if (b_zero) res_v = 32'hFFFF_FFFF;
        else        res_v = q;
      end
      OP_REM: begin
        if (b_zero)     res_v = a;
        else if (a_neg) res_v = 32'd0 - r;
        else            res_v = r;
      end
      OP_REMU: begin
        if (b_zero) res_v = a;
        else        res_v = r;
      end
      default: res_v = 32'd0;
    endcase
    return res_v;
  endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring radix-2 division step; kept separate so two can be chained later.
module div_step (
  input  logic [31:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic [31:0] quo_next
);

  logic [32:0] shifted_s;
  logic [31:0] diff_s;
  logic        ge_s;

  // Shift {rem,quo} left, trial-subtract the divisor and keep it if non-negative.
  always_comb begin
    shifted_s = {rem, quo[31]};
    ge_s      = (shifted_s >= {1'b0, divisor});
    // Low 32 bits suffice: when ge_s the true difference is below divisor.
    diff_s    = shifted_s[31:0] - divisor;
    if (ge_s) rem_next = diff_s;
    else      rem_next = shifted_s[31:0];
    quo_next  = {quo[30:0], ge_s};
  end

endmodule

// File: rtl/div_iter.sv
// Iterative 32-bit DIV/DIVU/REM/REMU responder with start/stall/eoc handshake.
// Optional macro DIV_EARLY_OUT_EN: B==0 or |A|<|B| finishes in one cycle.
module div_iter
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stall,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        eoc,
  output logic        busy,
  output logic [31:0] res
);

  div_state_t  state_r, state_next_s;
  div_op_t     op_s, op_r;
  logic        a_neg_s, b_neg_s, b_zero_s, early_s;
  logic [31:0] a_mag_s, b_mag_s;
  logic        a_neg_r, b_neg_r, b_zero_r;
  logic [31:0] a_r, b_mag_r, rem_r, quo_r, res_r;
  logic [31:0] rem_next_s, quo_next_s;
  logic [4:0]  cnt_r;
  logic        eoc_r, busy_r;

  div_step u_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .divisor  (b_mag_r),
    .rem_next (rem_next_s),
    .quo_next (quo_next_s)
  );

  // Operand pre-processing: magnitudes are taken only for signed ops.
  always_comb begin
    op_s     = div_op_t'(op);
    a_neg_s  = ~op[0] & A[31];
    b_neg_s  = ~op[0] & B[31];
    a_mag_s  = div_abs(A, a_neg_s);
    b_mag_s  = div_abs(B, b_neg_s);
    b_zero_s = (B == 32'd0);
`ifdef DIV_EARLY_OUT_EN
    early_s  = b_zero_s | (a_mag_s < b_mag_s);
`else
    early_s  = 1'b0;
`endif
  end

  // Next-state logic; stall holds the current state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start && !stall) state_next_s = early_s ? S_DONE : S_RUN;
        else                 state_next_s = S_IDLE;
      end
      S_RUN: begin
        if (!stall && (cnt_r == 5'd0)) state_next_s = S_DONE;
        else                           state_next_s = S_RUN;
      end
      S_DONE: begin
        if (!stall) state_next_s = S_IDLE;
        else        state_next_s = S_DONE;
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // State register with eoc/busy registered from the next state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
      eoc_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      eoc_r   <= (state_next_s == S_DONE);
      busy_r  <= (state_next_s != S_IDLE);
    end
  end

  // Datapath: operand capture, per-cycle step and final result latch.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_r     <= OP_DIV;
      a_r      <= 32'd0;
      a_neg_r  <= 1'b0;
      b_neg_r  <= 1'b0;
      b_zero_r <= 1'b0;
      b_mag_r  <= 32'd0;
      rem_r    <= 32'd0;
      quo_r    <= 32'd0;
      cnt_r    <= 5'd0;
      res_r    <= 32'd0;
    end else if (!stall) begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            op_r     <= op_s;
            a_r      <= A;
            a_neg_r  <= a_neg_s;
            b_neg_r  <= b_neg_s;
            b_zero_r <= b_zero_s;
            b_mag_r  <= b_mag_s;
            rem_r    <= 32'd0;
            quo_r    <= a_mag_s;
            cnt_r    <= 5'd31;
            // Early-out: quotient 0 (or all ones for B==0), remainder |A|.
            if (early_s)
              res_r <= div_fix(op_s, A, 32'd0, a_mag_s, a_neg_s, b_neg_s, b_zero_s);
            else
              res_r <= res_r;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        S_RUN: begin
          rem_r <= rem_next_s;
          quo_r <= quo_next_s;
          if (cnt_r == 5'd0) begin
            cnt_r <= 5'd0;
            res_r <= div_fix(op_r, a_r, quo_next_s, rem_next_s, a_neg_r, b_neg_r, b_zero_r);
          end else begin
            cnt_r <= cnt_r - 5'd1;
          end
        end
        S_DONE: begin
          res_r <= res_r;
        end
        default: begin
          cnt_r <= 5'd0;
        end
      endcase
    end
  end

  assign eoc  = eoc_r;
  assign busy = busy_r;
  assign res  = res_r;

endmodule

// File: tb/tb_div_iter.sv
// Directed-vector bench for div_iter: results, latency, stall, reset abort.
module tb_div_iter;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        stall;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        eoc;
  logic        busy;
  logic [31:0] res;

  int n_vec = 0;
  int n_err = 0;

  div_iter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .stall   (stall),
    .op      (op),
    .A       (A),
    .B       (B),
    .eoc     (eoc),
    .busy    (busy),
    .res     (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Start at T0, wait for eoc, check latency/result, optional stall in RUN and DONE.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input logic early,
                        input int stall_at, input int stall_len, input int done_hold);
    int k;
    int lat;
    lat = 33 + stall_len;
`ifdef DIV_EARLY_OUT_EN
    if (early) lat = 1;
`endif
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; A = $urandom; B = $urandom;
    k = 1;
    while (!eoc && k < 120) begin
      if (stall_at > 0 && k == stall_at) stall = 1'b1;
      if (stall_at > 0 && k == stall_at + stall_len) stall = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    chk({tag, " latency"}, 32'(k), 32'(lat));
    chk({tag, " res"}, res, exp);
    chk({tag, " busy"}, {31'd0, busy}, 32'd1);
    if (done_hold > 0) begin
      stall = 1'b1;
      for (int i = 0; i < done_hold; i++) begin
        @(posedge clk); #1;
        chk({tag, " eoc held"}, {31'd0, eoc}, 32'd1);
        chk({tag, " res held"}, res, exp);
      end
      stall = 1'b0;
    end
    @(posedge clk); #1;
    chk({tag, " eoc after"}, {31'd0, eoc}, 32'd0);
    chk({tag, " idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; stall = 1'b0; op = 2'd0; A = 32'd0; B = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset eoc", {31'd0, eoc}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset res", res, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_op("divu 100/7",  2'd1, 32'd100, 32'd7, 32'd14, 1'b0, 0, 0, 0);
    run_op("remu 100%7",  2'd3, 32'd100, 32'd7, 32'd2, 1'b0, 0, 0, 0);
    run_op("div -7/2",    2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 0, 0, 0);
    run_op("rem -7%2",    2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 0, 0, 0);
    run_op("div 7/-2",    2'd0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 0, 0, 0);
    run_op("rem 7%-2",    2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 0, 0, 0);
    run_op("div ovf",     2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0, 0, 0);
    run_op("rem ovf",     2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 0, 0, 0);
    run_op("divu max/1",  2'd1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 0, 0, 0);
    run_op("divu /0",     2'd1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1'b1, 0, 0, 0);
    run_op("div /0",      2'd0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1'b1, 0, 0, 0);
    run_op("rem /0",      2'd2, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b1, 0, 0, 0);
    run_op("remu /0",     2'd3, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b1, 0, 0, 0);
    run_op("div -100/0",  2'd0, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FFFF, 1'b1, 0, 0, 0);
    run_op("rem -100%0",  2'd2, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C, 1'b1, 0, 0, 0);
    run_op("divu 3/10",   2'd1, 32'd3, 32'd10, 32'd0, 1'b1, 0, 0, 0);
    run_op("rem -3%10",   2'd2, 32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD, 1'b1, 0, 0, 0);
    run_op("stall run",   2'd1, 32'd100, 32'd7, 32'd14, 1'b0, 5, 5, 3);

    // Abort mid-RUN with reset, then restart and expect a clean result.
    @(negedge clk);
    start = 1'b1; op = 2'd1; A = 32'd1000; B = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("busy at T10", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("abort eoc", {31'd0, eoc}, 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort res", res, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_op("after abort", 2'd0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_iter.md
# div_iter

Iterative 32-bit RISC-V M-extension divider: the multi-cycle responder the EX stage drives with the same start/stall/eoc handshake it uses for its carry-less multiplier. It produces DIV, DIVU, REM and REMU results with a restoring radix-2 algorithm, one quotient bit per unstalled cycle. It sits beside the ALU inside EX. Its eoc output feeds EX's stall request.

## Interface
- No parameters; width fixed at 32.
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- start  in  1  begin operation; sampled only in IDLE
- stall  in  1  external pipeline stall; freezes all state
- op  in  2  0 DIV, 1 DIVU, 2 REM, 3 REMU
- A  in  32  dividend (Op1)
- B  in  32  divisor (Op2)
- eoc  out  1  result valid; high exactly while in DONE
- busy  out  1  high in RUN or DONE
- res  out  32  result; stable while eoc is high

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state IDLE, eoc 0, busy 0, res 0, counter 0.
- IDLE, start=1, stall=0:
  - latch op and operand sign flags;
  - latch |A| and |B|, taking magnitudes only for signed ops;
  - clear the 32-bit partial remainder, load the quotient register with |A|, set counter 31;
  - go to RUN.
- RUN, stall=0: perform one step.
  - {rem,quo} shifts left by 1.
  - If the shifted rem ≥ |B| (33-bit unsigned compare), subtract |B| and set quo[0]=1.
  - Counter decrements.
  - The step taken at counter 0 also transitions to DONE.
- Leaving RUN to DONE: apply sign correction and latch res.
  - DIV: q negated when signs differ and B≠0.
  - REM: remainder takes the dividend's sign.
  - B=0 in any op: quotient all ones, remainder = A (unnegated).
  - Overflow, DIV -2^31 / -1: 0x80000000, remainder 0. This falls out of the unsigned datapath; no special case.
- DONE, stall=0: go to IDLE next cycle.
- DONE, stall=1: hold DONE with eoc high.
- start in RUN or DONE: ignored.
- stall=1 in any state: no register changes.

## Timing
- start sampled at cycle T0 (stall low throughout):
  - RUN during T1..T32;
  - DONE (eoc=1, res valid) during T33;
  - IDLE at T34.
- Latency 33 cycles plus one per stalled cycle.
- Back-to-back: a start at T34 (in IDLE) is accepted. eoc is guaranteed low during T34, so an EX-side stall request for the new operation is not falsely released.
- reset_n low mid-RUN or in DONE: IDLE at the next edge, eoc 0 and res 0. The partial result is discarded.
- A and B need only be valid in the start cycle.

## Configuration
- DIV_EARLY_OUT_EN defined: a start with B==0 goes IDLE→DONE directly.
  - The special-case result is written to res.
  - eoc is high at T1 (latency 1).
  - Unsigned or magnitude |A|<|B| also goes directly to DONE with quotient 0 and remainder A.
- Undefined: every operation takes the full 33 cycles. Results are identical either way.

## Structure
- Shared constants:
  - DIV, DIVU, REM, REMU op_EX encodings go in the common OPTYPE.vh constant set next to the ALU ops.
  - The div_op_t 2-bit typedef and the state enum go in package div_pkg.
- Sub-module div_step (combinational): one restoring step.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Isolated so a later radix-4 variant can instantiate two.
- Sign pre/post-processing stays in div_iter.

## Test plan
- DIVU A=100, B=7, start at T0 → eoc high only at T33, res=14; REMU same operands → res=2.
- DIV A=-7 (0xFFFFFFF9), B=2 → res=0xFFFFFFFD (-3); REM → res=0xFFFFFFFF (-1).
- DIV A=0x80000000, B=0xFFFFFFFF → res=0x80000000; REM → res=0.
- B=0, A=0x12345678: DIVU → 0xFFFFFFFF, DIV → 0xFFFFFFFF, REM/REMU → 0x12345678. Check eoc at T33 without the macro and at T1 with it.
- stall held for 5 cycles mid-RUN → eoc at T38, unchanged result. stall held in DONE → eoc and res held until stall drops, then IDLE.
- reset_n low at T10 of an operation → IDLE at the next edge. A new start at T12 gives the correct result at T45 with no residue from the aborted operation.
